// File: rtl/ysyx_22040750_axi_arbiter.sv
// ysyx_22040750_axi_arbiter: AXI4 arbiter (3 read / 2 write masters); define ARB_ROUND_ROBIN_EN for round-robin, else fixed priority
module ysyx_22040750_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic [ADDR_W-1:0]   I_ch0_araddr,
  input  logic [7:0]          I_ch0_arlen,
  input  logic [2:0]          I_ch0_arsize,
  input  logic [1:0]          I_ch0_arburst,
  input  logic                I_ch0_arvalid,
  output logic                O_ch0_arready,
  output logic [DATA_W-1:0]   O_ch0_rdata,
  output logic                O_ch0_rvalid,
  output logic                O_ch0_rlast,
  input  logic                I_ch0_rready,
  input  logic [ADDR_W-1:0]   I_ch1_araddr,
  input  logic [7:0]          I_ch1_arlen,
  input  logic [2:0]          I_ch1_arsize,
  input  logic [1:0]          I_ch1_arburst,
  input  logic                I_ch1_arvalid,
  output logic                O_ch1_arready,
  output logic [DATA_W-1:0]   O_ch1_rdata,
  output logic                O_ch1_rvalid,
  output logic                O_ch1_rlast,
  input  logic                I_ch1_rready,
  input  logic [ADDR_W-1:0]   I_ch2_araddr,
  input  logic [7:0]          I_ch2_arlen,
  input  logic [2:0]          I_ch2_arsize,
  input  logic [1:0]          I_ch2_arburst,
  input  logic                I_ch2_arvalid,
  output logic                O_ch2_arready,
  output logic [DATA_W-1:0]   O_ch2_rdata,
  output logic                O_ch2_rvalid,
  output logic                O_ch2_rlast,
  input  logic                I_ch2_rready,
  input  logic [ADDR_W-1:0]   I_ch1_awaddr,
  input  logic [7:0]          I_ch1_awlen,
  input  logic [2:0]          I_ch1_awsize,
  input  logic [1:0]          I_ch1_awburst,
  input  logic                I_ch1_awvalid,
  output logic                O_ch1_awready,
  input  logic [DATA_W-1:0]   I_ch1_wdata,
  input  logic [DATA_W/8-1:0] I_ch1_wstrb,
  input  logic                I_ch1_wlast,
  input  logic                I_ch1_wvalid,
  output logic                O_ch1_wready,
  output logic                O_ch1_bvalid,
  input  logic                I_ch1_bready,
  input  logic [ADDR_W-1:0]   I_ch2_awaddr,
  input  logic [7:0]          I_ch2_awlen,
  input  logic [2:0]          I_ch2_awsize,
  input  logic [1:0]          I_ch2_awburst,
  input  logic                I_ch2_awvalid,
  output logic                O_ch2_awready,
  input  logic [DATA_W-1:0]   I_ch2_wdata,
  input  logic [DATA_W/8-1:0] I_ch2_wstrb,
  input  logic                I_ch2_wlast,
  input  logic                I_ch2_wvalid,
  output logic                O_ch2_wready,
  output logic                O_ch2_bvalid,
  input  logic                I_ch2_bready,
  output logic [ADDR_W-1:0]   O_axi_araddr,
  output logic [7:0]          O_axi_arlen,
  output logic [2:0]          O_axi_arsize,
  output logic [1:0]          O_axi_arburst,
  output logic                O_axi_arvalid,
  input  logic                I_axi_arready,
  input  logic [DATA_W-1:0]   I_axi_rdata,
  input  logic                I_axi_rvalid,
  input  logic                I_axi_rlast,
  output logic                O_axi_rready,
  output logic [ADDR_W-1:0]   O_axi_awaddr,
  output logic [7:0]          O_axi_awlen,
  output logic [2:0]          O_axi_awsize,
  output logic [1:0]          O_axi_awburst,
  output logic                O_axi_awvalid,
  input  logic                I_axi_awready,
  output logic [DATA_W-1:0]   O_axi_wdata,
  output logic [DATA_W/8-1:0] O_axi_wstrb,
  output logic                O_axi_wlast,
  output logic                O_axi_wvalid,
  input  logic                I_axi_wready,
  input  logic                I_axi_bvalid,
  output logic                O_axi_bready
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  rstate_t rstate;
  wstate_t wstate;
  logic [2:0] rgnt, rsel, rreq, ra, rd;
  logic [1:0] wgnt, wsel, wreq, wa, wd, wb;
  assign rreq = {I_ch2_arvalid, I_ch1_arvalid, I_ch0_arvalid};
  assign wreq = {I_ch2_awvalid, I_ch1_awvalid};
`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] rptr, rhi;
  logic [1:0] wptr, whi;
  // one-hot pointer marks the highest-priority channel; search from it, wrap to the lowest requester
  always_comb begin
    rhi = rreq & ~(rptr - 3'd1);
    whi = wreq & ~(wptr - 2'd1);
    rsel = |rhi ? rhi & -rhi : rreq & -rreq;
    wsel = |whi ? whi & -whi : wreq & -wreq;
  end
`else
  always_comb begin
    rsel = rreq[1] ? 3'b010 : rreq[2] ? 3'b100 : {2'b00, rreq[0]};
    wsel = wreq[0] ? 2'b01 : {wreq[1], 1'b0};
  end
`endif
  assign ra = rstate == R_ADDR ? rgnt : 3'b000;
  assign rd = rstate == R_DATA ? rgnt : 3'b000;
  assign wa = wstate == W_ADDR ? wgnt : 2'b00;
  assign wd = wstate == W_DATA ? wgnt : 2'b00;
  assign wb = wstate == W_RESP ? wgnt : 2'b00;
  assign O_axi_araddr  = ({ADDR_W{ra[0]}} & I_ch0_araddr) | ({ADDR_W{ra[1]}} & I_ch1_araddr) | ({ADDR_W{ra[2]}} & I_ch2_araddr);
  assign O_axi_arlen   = ({8{ra[0]}} & I_ch0_arlen) | ({8{ra[1]}} & I_ch1_arlen) | ({8{ra[2]}} & I_ch2_arlen);
  assign O_axi_arsize  = ({3{ra[0]}} & I_ch0_arsize) | ({3{ra[1]}} & I_ch1_arsize) | ({3{ra[2]}} & I_ch2_arsize);
  assign O_axi_arburst = ({2{ra[0]}} & I_ch0_arburst) | ({2{ra[1]}} & I_ch1_arburst) | ({2{ra[2]}} & I_ch2_arburst);
  assign O_axi_arvalid = |(ra & rreq);
  assign O_axi_rready  = |(rd & {I_ch2_rready, I_ch1_rready, I_ch0_rready});
  assign O_ch0_arready = ra[0] & I_axi_arready;
  assign O_ch1_arready = ra[1] & I_axi_arready;
  assign O_ch2_arready = ra[2] & I_axi_arready;
  assign O_ch0_rvalid  = rd[0] & I_axi_rvalid;
  assign O_ch1_rvalid  = rd[1] & I_axi_rvalid;
  assign O_ch2_rvalid  = rd[2] & I_axi_rvalid;
  assign O_ch0_rlast   = rd[0] & I_axi_rlast;
  assign O_ch1_rlast   = rd[1] & I_axi_rlast;
  assign O_ch2_rlast   = rd[2] & I_axi_rlast;
  assign O_ch0_rdata   = I_axi_rdata;
  assign O_ch1_rdata   = I_axi_rdata;
  assign O_ch2_rdata   = I_axi_rdata;
  assign O_axi_awaddr  = ({ADDR_W{wa[0]}} & I_ch1_awaddr) | ({ADDR_W{wa[1]}} & I_ch2_awaddr);
  assign O_axi_awlen   = ({8{wa[0]}} & I_ch1_awlen) | ({8{wa[1]}} & I_ch2_awlen);
  assign O_axi_awsize  = ({3{wa[0]}} & I_ch1_awsize) | ({3{wa[1]}} & I_ch2_awsize);
  assign O_axi_awburst = ({2{wa[0]}} & I_ch1_awburst) | ({2{wa[1]}} & I_ch2_awburst);
  assign O_axi_awvalid = |(wa & wreq);
  assign O_axi_wdata   = ({DATA_W{wd[0]}} & I_ch1_wdata) | ({DATA_W{wd[1]}} & I_ch2_wdata);
  assign O_axi_wstrb   = ({(DATA_W/8){wd[0]}} & I_ch1_wstrb) | ({(DATA_W/8){wd[1]}} & I_ch2_wstrb);
  assign O_axi_wlast   = (wd[0] & I_ch1_wlast) | (wd[1] & I_ch2_wlast);
  assign O_axi_wvalid  = |(wd & {I_ch2_wvalid, I_ch1_wvalid});
  assign O_axi_bready  = |(wb & {I_ch2_bready, I_ch1_bready});
  assign O_ch1_awready = wa[0] & I_axi_awready;
  assign O_ch2_awready = wa[1] & I_axi_awready;
  assign O_ch1_wready  = wd[0] & I_axi_wready;
  assign O_ch2_wready  = wd[1] & I_axi_wready;
  assign O_ch1_bvalid  = wb[0] & I_axi_bvalid;
  assign O_ch2_bvalid  = wb[1] & I_axi_bvalid;
  always_ff @(posedge I_clk)
    if (I_rst) begin
      rstate <= R_IDLE;
      rgnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rptr <= 3'b001;
`endif
    end else
      case (rstate)
        R_IDLE: if (|rreq) begin
          rgnt <= rsel;
          rstate <= R_ADDR;
        end
        R_ADDR: if (O_axi_arvalid && I_axi_arready) rstate <= R_DATA;
        R_DATA: if (I_axi_rvalid && O_axi_rready && I_axi_rlast) begin
          rstate <= R_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          rptr <= {rgnt[1:0], rgnt[2]};
`endif
        end
        default: rstate <= R_IDLE;
      endcase
  always_ff @(posedge I_clk)
    if (I_rst) begin
      wstate <= W_IDLE;
      wgnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      wptr <= 2'b01;
`endif
    end else
      case (wstate)
        W_IDLE: if (|wreq) begin
          wgnt <= wsel;
          wstate <= W_ADDR;
        end
        W_ADDR: if (O_axi_awvalid && I_axi_awready) wstate <= W_DATA;
        W_DATA: if (O_axi_wvalid && I_axi_wready && O_axi_wlast) wstate <= W_RESP;
        W_RESP: if (I_axi_bvalid && O_axi_bready) begin
          wstate <= W_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          wptr <= {wgnt[0], wgnt[1]};
`endif
        end
        default: wstate <= W_IDLE;
      endcase
endmodule

// File: tb/tb_ysyx_22040750_axi_arbiter.sv
// tb_ysyx_22040750_axi_arbiter: directed self-checking bench for the AXI arbiter
module tb_ysyx_22040750_axi_arbiter;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [31:0] araddr [3];
  logic [7:0]  arlen [3];
  logic [2:0]  arsize [3];
  logic [1:0]  arburst [3];
  logic        arvalid [3], arready [3], rvalid [3], rlast [3], rready [3];
  logic [63:0] rdata [3];
  logic [31:0] awaddr [1:2];
  logic [7:0]  awlen [1:2];
  logic [2:0]  awsize [1:2];
  logic [1:0]  awburst [1:2];
  logic        awvalid [1:2], awready [1:2], wlast [1:2], wvalid [1:2], wready [1:2], bvalid [1:2], bready [1:2];
  logic [63:0] wdata [1:2];
  logic [7:0]  wstrb [1:2];
  logic [31:0] axi_araddr, axi_awaddr;
  logic [7:0]  axi_arlen, axi_awlen, axi_wstrb;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [1:0]  axi_arburst, axi_awburst;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [63:0] axi_rdata, axi_wdata;
  int n_vec = 0, n_err = 0;
  int first, second;
  ysyx_22040750_axi_arbiter dut (
    .I_clk(clk), .I_rst(rst),
    .I_ch0_araddr(araddr[0]), .I_ch0_arlen(arlen[0]), .I_ch0_arsize(arsize[0]), .I_ch0_arburst(arburst[0]),
    .I_ch0_arvalid(arvalid[0]), .O_ch0_arready(arready[0]), .O_ch0_rdata(rdata[0]), .O_ch0_rvalid(rvalid[0]),
    .O_ch0_rlast(rlast[0]), .I_ch0_rready(rready[0]),
    .I_ch1_araddr(araddr[1]), .I_ch1_arlen(arlen[1]), .I_ch1_arsize(arsize[1]), .I_ch1_arburst(arburst[1]),
    .I_ch1_arvalid(arvalid[1]), .O_ch1_arready(arready[1]), .O_ch1_rdata(rdata[1]), .O_ch1_rvalid(rvalid[1]),
    .O_ch1_rlast(rlast[1]), .I_ch1_rready(rready[1]),
    .I_ch2_araddr(araddr[2]), .I_ch2_arlen(arlen[2]), .I_ch2_arsize(arsize[2]), .I_ch2_arburst(arburst[2]),
    .I_ch2_arvalid(arvalid[2]), .O_ch2_arready(arready[2]), .O_ch2_rdata(rdata[2]), .O_ch2_rvalid(rvalid[2]),
    .O_ch2_rlast(rlast[2]), .I_ch2_rready(rready[2]),
    .I_ch1_awaddr(awaddr[1]), .I_ch1_awlen(awlen[1]), .I_ch1_awsize(awsize[1]), .I_ch1_awburst(awburst[1]),
    .I_ch1_awvalid(awvalid[1]), .O_ch1_awready(awready[1]), .I_ch1_wdata(wdata[1]), .I_ch1_wstrb(wstrb[1]),
    .I_ch1_wlast(wlast[1]), .I_ch1_wvalid(wvalid[1]), .O_ch1_wready(wready[1]), .O_ch1_bvalid(bvalid[1]),
    .I_ch1_bready(bready[1]),
    .I_ch2_awaddr(awaddr[2]), .I_ch2_awlen(awlen[2]), .I_ch2_awsize(awsize[2]), .I_ch2_awburst(awburst[2]),
    .I_ch2_awvalid(awvalid[2]), .O_ch2_awready(awready[2]), .I_ch2_wdata(wdata[2]), .I_ch2_wstrb(wstrb[2]),
    .I_ch2_wlast(wlast[2]), .I_ch2_wvalid(wvalid[2]), .O_ch2_wready(wready[2]), .O_ch2_bvalid(bvalid[2]),
    .I_ch2_bready(bready[2]),
    .O_axi_araddr(axi_araddr), .O_axi_arlen(axi_arlen), .O_axi_arsize(axi_arsize), .O_axi_arburst(axi_arburst),
    .O_axi_arvalid(axi_arvalid), .I_axi_arready(axi_arready), .I_axi_rdata(axi_rdata), .I_axi_rvalid(axi_rvalid),
    .I_axi_rlast(axi_rlast), .O_axi_rready(axi_rready),
    .O_axi_awaddr(axi_awaddr), .O_axi_awlen(axi_awlen), .O_axi_awsize(axi_awsize), .O_axi_awburst(axi_awburst),
    .O_axi_awvalid(axi_awvalid), .I_axi_awready(axi_awready), .O_axi_wdata(axi_wdata), .O_axi_wstrb(axi_wstrb),
    .O_axi_wlast(axi_wlast), .O_axi_wvalid(axi_wvalid), .I_axi_wready(axi_wready), .I_axi_bvalid(axi_bvalid),
    .O_axi_bready(axi_bready)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req_read(input int ch, input logic [31:0] addr, input int beats);
    arvalid[ch] = 1'b1;
    araddr[ch] = addr;
    arlen[ch] = 8'(beats - 1);
    arsize[ch] = 3'd3;
    arburst[ch] = 2'd1;
    #1 chk("ar_bubble", axi_arvalid, 0);
    tick;
    #1 chk("ar_valid", axi_arvalid, 1);
  endtask
  task automatic rd_serve(input int ch, input logic [31:0] addr, input int beats, input bit hold);
    axi_arready = 1'b1;
    #1;
    chk("araddr", axi_araddr, addr);
    chk("arlen", axi_arlen, 64'(beats - 1));
    chk("arsize", axi_arsize, 3);
    for (int j = 0; j < 3; j++) chk($sformatf("arready%0d", j), arready[j], 64'(j == ch));
    tick;
    arvalid[ch] = 1'b0;
    if (hold) begin
      axi_rvalid = 1'b1;
      axi_rdata = 64'hA;
      axi_rlast = 1'b0;
      rready[ch] = 1'b0;
      #1;
      chk("hold_rready", axi_rready, 0);
      chk("hold_rvalid", rvalid[ch], 1);
      tick;
    end
    rready[ch] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      axi_rvalid = 1'b1;
      axi_rdata = 64'hA + 64'(b);
      axi_rlast = b == beats - 1;
      #1;
      chk("rvalid", rvalid[ch], 1);
      chk("rdata", rdata[ch], 64'hA + 64'(b));
      chk("rlast", rlast[ch], 64'(b == beats - 1));
      chk("rready", axi_rready, 1);
      for (int j = 0; j < 3; j++)
        if (j != ch) begin
          chk($sformatf("rvalid_other%0d", j), rvalid[j], 0);
          chk($sformatf("arready_other%0d", j), arready[j], 0);
        end
      tick;
    end
    axi_rvalid = 1'b0;
    axi_rlast = 1'b0;
    rready[ch] = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      araddr[i] = '0; arlen[i] = '0; arsize[i] = '0; arburst[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b1;
    end
    for (int i = 1; i <= 2; i++) begin
      awaddr[i] = '0; awlen[i] = '0; awsize[i] = '0; awburst[i] = '0; awvalid[i] = 1'b0;
      wdata[i] = '0; wstrb[i] = '0; wlast[i] = 1'b0; wvalid[i] = 1'b1; bready[i] = 1'b1;
    end
    axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rlast = 1'b1; axi_rdata = '0;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b1;
    tick;
    tick;
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_wvalid", axi_wvalid, 0);
    chk("rst_bready", axi_bready, 0);
    chk("rst_arready0", arready[0], 0);
    chk("rst_rvalid1", rvalid[1], 0);
    chk("rst_wready1", wready[1], 0);
    chk("rst_bvalid2", bvalid[2], 0);
    for (int i = 0; i < 3; i++) rready[i] = 1'b0;
    for (int i = 1; i <= 2; i++) begin wvalid[i] = 1'b0; bready[i] = 1'b0; end
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_awready = 1'b0; axi_bvalid = 1'b0;
    rst = 1'b0;
    // single icache read with one back-pressured beat
    req_read(0, 32'h1000, 2);
    chk("arready_gated", arready[0], 0);
    rd_serve(0, 32'h1000, 2, 1'b1);
    #1 chk("idle_rready", axi_rready, 0);
    // simultaneous ch0/ch1 after a fresh reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    first = 0; second = 1;
`else
    first = 1; second = 0;
`endif
    for (int i = 0; i < 2; i++) begin
      arvalid[i] = 1'b1; araddr[i] = 32'h100 * (i + 1); arlen[i] = 8'd0; arsize[i] = 3'd3;
    end
    #1 chk("pair_bubble", axi_arvalid, 0);
    tick;
    rd_serve(first, 32'h100 * (first + 1), 1, 1'b0);
    #1 chk("pair_idle", axi_arvalid, 0);
    tick;
    rd_serve(second, 32'h100 * (second + 1), 1, 1'b0);
    // ch2 request arriving during a ch1 burst waits until rlast
    req_read(1, 32'h300, 4);
    arvalid[2] = 1'b1; araddr[2] = 32'h400; arlen[2] = 8'd0; arsize[2] = 3'd3;
    rd_serve(1, 32'h300, 4, 1'b0);
    #1 chk("ch2_wait_idle", axi_arvalid, 0);
    tick;
    #1 chk("ch2_ar_issued", axi_arvalid, 1);
    rd_serve(2, 32'h400, 1, 1'b0);
    // ch1 write burst concurrent with a ch0 read
    awvalid[1] = 1'b1; awaddr[1] = 32'h500; awlen[1] = 8'd3; awsize[1] = 3'd3; wvalid[1] = 1'b1;
    wdata[1] = 64'h11; wstrb[1] = 8'hFF; axi_awready = 1'b0; axi_wready = 1'b1;
    arvalid[0] = 1'b1; araddr[0] = 32'h600; arlen[0] = 8'd0; axi_arready = 1'b0;
    #1 chk("aw_bubble", axi_awvalid, 0);
    tick;
    chk("aw_valid", axi_awvalid, 1);
    chk("aw_addr", axi_awaddr, 32'h500);
    chk("aw_len", axi_awlen, 3);
    chk("conc_arvalid", axi_arvalid, 1);
    chk("w_before_aw", axi_wvalid, 0);
    chk("wready_before_aw", wready[1], 0);
    axi_awready = 1'b1; axi_arready = 1'b1;
    #1;
    chk("awready1", awready[1], 1);
    chk("awready2", awready[2], 0);
    chk("conc_arready0", arready[0], 1);
    tick;
    awvalid[1] = 1'b0; arvalid[0] = 1'b0; rready[0] = 1'b1;
    axi_rvalid = 1'b1; axi_rdata = 64'hC; axi_rlast = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wdata[1] = 64'h11 + 64'(b);
      wlast[1] = b == 3;
      #1;
      chk("wvalid", axi_wvalid, 1);
      chk("wdata", axi_wdata, 64'h11 + 64'(b));
      chk("wstrb", axi_wstrb, 8'hFF);
      chk("wlast", axi_wlast, 64'(b == 3));
      chk("wready1", wready[1], 1);
      chk("wready2", wready[2], 0);
      if (b == 0) chk("conc_rvalid0", rvalid[0], 1);
      tick;
      axi_rvalid = 1'b0; axi_rlast = 1'b0; rready[0] = 1'b0;
    end
    wvalid[1] = 1'b0; wlast[1] = 1'b0; axi_bvalid = 1'b1; bready[1] = 1'b1;
    #1;
    chk("bvalid1", bvalid[1], 1);
    chk("bvalid2", bvalid[2], 0);
    chk("bready", axi_bready, 1);
    chk("resp_wvalid", axi_wvalid, 0);
    tick;
    axi_bvalid = 1'b0; bready[1] = 1'b0;
    #1 chk("w_idle_bready", axi_bready, 0);
    // single-beat ch2 write
    awvalid[2] = 1'b1; awaddr[2] = 32'h700; awlen[2] = 8'd0;
    tick;
    chk("aw2_addr", axi_awaddr, 32'h700);
    chk("aw2_ready", awready[2], 1);
    chk("aw2_ready1", awready[1], 0);
    tick;
    awvalid[2] = 1'b0; wvalid[2] = 1'b1; wlast[2] = 1'b1; wdata[2] = 64'h77;
    #1;
    chk("w2_data", axi_wdata, 64'h77);
    chk("w2_ready", wready[2], 1);
    tick;
    wvalid[2] = 1'b0; wlast[2] = 1'b0; axi_bvalid = 1'b1; bready[2] = 1'b1;
    #1;
    chk("b2_valid", bvalid[2], 1);
    chk("b2_valid1", bvalid[1], 0);
    tick;
    axi_bvalid = 1'b0; bready[2] = 1'b0;
    // reset in the middle of a ch1 read burst
    req_read(1, 32'h800, 4);
    axi_arready = 1'b1;
    tick;
    arvalid[1] = 1'b0; rready[1] = 1'b1; axi_rvalid = 1'b1;
    #1 chk("mid_rvalid", rvalid[1], 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("post_rst_rvalid", rvalid[1], 0);
    chk("post_rst_rready", axi_rready, 0);
    chk("post_rst_arvalid", axi_arvalid, 0);
    axi_rvalid = 1'b0; rready[1] = 1'b0;
    req_read(0, 32'h900, 2);
    rd_serve(0, 32'h900, 2, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ysyx_22040750_axi_arbiter.md
# ysyx_22040750_axi_arbiter

Shared-bus arbiter between the cache/uncached masters and the single external AXI4 master port. Arbitrates the AR/R channels among three requesters (icache, dcache, uncached MMIO port) and the AW/W/B channels between two (dcache write-back, uncached MMIO port). A grant is held for a whole transaction. Read and write paths are independent FSMs and may be busy at the same time.

## Interface
Parameters:
- ADDR_W, 32, AXI address width
- DATA_W, 64, AXI data width; wstrb is DATA_W/8

Ports (chN = ch0 icache, ch1 dcache, ch2 uncached; ch0 has no write ports):
- I_clk  in  1  single clock, all state on rising edge
- I_rst  in  1  synchronous reset, active-high
- I_chN_araddr/arlen/arsize/arburst  in  ADDR_W/8/3/2  read request bundle, N=0..2
- I_chN_arvalid  in  1  read request valid, N=0..2
- O_chN_arready  out  1  read request accepted, N=0..2
- O_chN_rdata  out  DATA_W  read data broadcast, N=0..2
- O_chN_rvalid/rlast  out  1/1  read beat valid/last, granted channel only
- I_chN_rready  in  1  read beat ready, N=0..2
- I_chN_awaddr/awlen/awsize/awburst  in  ADDR_W/8/3/2  write request bundle, N=1..2
- I_chN_awvalid  in  1; O_chN_awready  out  1  write address handshake, N=1..2
- I_chN_wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write beat, N=1..2
- I_chN_wvalid  in  1; O_chN_wready  out  1  write beat handshake, N=1..2
- O_chN_bvalid  out  1; I_chN_bready  in  1  write response, N=1..2
- O_axi_ar*/aw*/w*  out  as above  bus-side request/beat signals, muxed from the granted channel
- I_axi_arready/awready/wready  in  1  bus-side accept
- I_axi_rdata/rvalid/rlast  in  DATA_W/1/1; O_axi_rready  out  1  bus read data
- I_axi_bvalid  in  1; O_axi_bready  out  1  bus write response

## Operation
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: if any I_chN_arvalid, latch grant rgnt (one-hot, 3 bits), go R_ADDR.
  - R_ADDR: O_axi_ar* = granted bundle; O_axi_arvalid = granted arvalid; O_chN_arready = I_axi_arready for the granted channel only. On arvalid&arready go R_DATA.
  - R_DATA: route I_axi_rvalid/rlast to the granted channel; O_axi_rready = granted rready. On rvalid&rready&rlast go R_IDLE.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE, same grant scheme over ch1/ch2 (wgnt).
  - W_ADDR: forward AW.
  - W_DATA: forward W beats; exit on wvalid&wready&wlast.
  - W_RESP: forward B; exit on bvalid&bready.
  - A master's W beats are never passed to the bus before its AW handshake completes.
- Ungranted channels: arready/rvalid/rlast/awready/wready/bvalid = 0. rdata is broadcast to all channels.
- Bus-side valid outputs are 0 in idle states; muxed data fields are don't-care, driven 0.
- Grant never changes mid-transaction, regardless of other requests; no timeout.

## Timing
- Reset: both FSMs idle; all valid/ready outputs 0; round-robin pointers point at the lowest channel (ch0 read, ch1 write).
- Grant latency: request seen in idle at edge k; bus-side arvalid/awvalid asserted in cycle k+1 (one cycle arbitration bubble).
- After the last R beat or B handshake, the FSM is idle for one cycle; a back-to-back request is granted at the next edge.
- Grant decision is registered. Muxes are combinational from registered grant; no combinational path from any I_chN_*valid to O_axi_*valid except through the granted channel's own valid.
- Simultaneous read and write transactions proceed concurrently. ch1/ch2 may hold a read and a write grant at once.
- Reset mid-burst: next edge returns to idle, outputs 0. The outstanding bus transaction is abandoned; the system resets the slave together.

## Configuration
- ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - Priority starts after the last granted channel; the pointer updates when a transaction completes.
- Undefined: fixed priority. Read: ch1 > ch2 > ch0. Write: ch1 > ch2. No pointer registers.

## Test plan
- Single icache read, arlen=1, 2 beats 0xA/0xB: O_axi_arvalid rises 1 cycle after I_ch0_arvalid; ch0 gets both beats, rlast on the 2nd; ch1/ch2 rvalid stay 0.
- ch0 and ch1 arvalid in the same cycle:
  - with ARB_ROUND_ROBIN_EN after reset, ch0 is served first, then ch1;
  - without it, ch1 is served first.
- ch2 arvalid asserted during a ch1 4-beat burst: ch2 arready stays 0 until ch1 rlast handshake; ch2 AR issued 2 cycles later.
- ch1 write, awlen=3, while ch0 reads concurrently: both bus channels active. W beats pass only after the AW handshake; bvalid reaches ch1 only; ch2 bvalid=0.
- I_axi_rvalid held with ch0 rready=0: O_axi_rready=0 and the beat is held until ch0 rready=1.
- I_rst pulsed in R_DATA of a ch1 burst: next cycle all outputs 0. A fresh ch0 request then completes normally.
